// File: rtl/fifo_rd_stream_ctrl_pkg.sv
// Shared interconnect definitions for the FIFO read-side controller.
// Byte-offset width of the RAM address bus as a function of data width.
package fifo_rd_stream_ctrl_pkg;

  function automatic int addr_nc_bits(input int width);
    int n;
    n = 0;
    while ((8 << n) < width) n++;
    return n;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_ctrl_if.sv
// RAM read port plus output stream bundle of the FIFO read controller.
// master = controller, slave = RAM / write side / consumer.
interface fifo_rd_stream_ctrl_if
  import fifo_rd_stream_ctrl_pkg::*;
#(
  parameter int FIFO_AWIDTH = 9,
  parameter int FIFO_WIDTH  = 32
);
  localparam int NCB = addr_nc_bits(FIFO_WIDTH);

  logic                       fifoPush;
  logic                       fifoFlush;
  logic [FIFO_AWIDTH+NCB-1:0] fifoRdAddr;
  logic [FIFO_WIDTH-1:0]      fifoRdData;
  logic                       fifoFull;
  logic                       fifoEmpty;
  logic [FIFO_AWIDTH:0]       fifoLevel;
  logic                       outValid;
  logic [FIFO_WIDTH-1:0]      outData;
  logic                       outReady;
  logic                       overflowErr;

  modport master (
    input  fifoPush, fifoFlush, fifoRdData, outReady,
    output fifoRdAddr, fifoFull, fifoEmpty, fifoLevel,
    output outValid, outData, overflowErr
  );

  modport slave (
    output fifoPush, fifoFlush, fifoRdData, outReady,
    input  fifoRdAddr, fifoFull, fifoEmpty, fifoLevel,
    input  outValid, outData, overflowErr
  );
endinterface

// File: rtl/fifo_rd_stream_ctrl_level_cnt.sv
// Occupancy counter for the FIFO RAM: inc/dec/clear with full/empty flags.
// Flags come straight from the registered count.
module fifo_level_cnt #(
  parameter int AW = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  input  logic        dec,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty
);
  localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else if (clr) begin
      level <= '0;
    end else if (inc & ~dec) begin
      level <= level + 1'b1;
    end else if (dec & ~inc) begin
      level <= level - 1'b1;
    end
  end

  assign full  = (level == DEPTH);
  assign empty = (level == '0);
endmodule

// File: rtl/fifo_rd_stream_ctrl.sv
// Read-side controller of the sync-write/async-read FIFO RAM.
// Moves committed words into a registered valid/ready output stage.
module fifo_rd_stream_ctrl
  import fifo_rd_stream_ctrl_pkg::*;
#(
  parameter int FIFO_AWIDTH = 9,
  parameter int FIFO_WIDTH  = 32
) (
  input logic                HCLK,
  input logic                HRESET,
  fifo_rd_stream_ctrl_if.master bus
);
  localparam int NCB    = addr_nc_bits(FIFO_WIDTH);
  localparam int ADDR_W = FIFO_AWIDTH + NCB;

  logic [FIFO_AWIDTH-1:0] rd_ptr;
  logic [FIFO_AWIDTH-1:0] wr_ptr;
  logic [FIFO_AWIDTH:0]   level;
  logic                   full;
  logic                   empty;
  logic                   out_valid;
  logic [FIFO_WIDTH-1:0]  out_data;
  logic                   ovf;
  logic                   push_ok;
  logic                   xfer;
  logic                   pop;

  assign push_ok = bus.fifoPush & ~full & ~bus.fifoFlush;
  assign xfer    = ~empty & (~out_valid | bus.outReady)
                 & ~bus.fifoFlush;
  assign pop     = out_valid & bus.outReady;

  fifo_level_cnt #(.AW(FIFO_AWIDTH)) u_level (
    .clk   (HCLK),
    .rst   (HRESET),
    .clr   (bus.fifoFlush),
    .inc   (push_ok),
    .dec   (xfer),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      ovf       <= 1'b0;
    end else begin
      if (bus.fifoPush & full & ~bus.fifoFlush) ovf <= 1'b1;
      if (bus.fifoFlush) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        out_valid <= 1'b0;
        out_data  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (xfer) begin
          out_data  <= bus.fifoRdData;
          out_valid <= 1'b1;
          rd_ptr    <= rd_ptr + 1'b1;
        end else if (pop) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  // wrPtr only mirrors the write side; its distance to rdPtr is the level
  a_ptr_level : assert property (@(posedge HCLK) disable iff (HRESET)
    level[FIFO_AWIDTH-1:0] == FIFO_AWIDTH'(wr_ptr - rd_ptr));

  assign bus.fifoRdAddr  = ADDR_W'(rd_ptr) << NCB;
  assign bus.fifoFull    = full;
  assign bus.fifoEmpty   = empty;
  assign bus.fifoLevel   = level;
  assign bus.outValid    = out_valid;
  assign bus.outData     = out_data;
  assign bus.overflowErr = ovf;
endmodule

// File: tb/tb_fifo_rd_stream_ctrl.sv
// Randomized bench for fifo_rd_stream_ctrl with a queue-based model.
// Includes a RAM / write-side model driving the async read port.
module tb_fifo_rd_stream_ctrl;
  localparam int AW    = 3;
  localparam int W     = 32;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] pdata = '0;
  logic chk_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_rd_stream_ctrl_if #(.FIFO_AWIDTH(AW), .FIFO_WIDTH(W)) bus ();

  fifo_rd_stream_ctrl #(.FIFO_AWIDTH(AW), .FIFO_WIDTH(W)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus)
  );

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  assign bus.fifoRdData = mem[bus.fifoRdAddr[AW+1:2]];

  // model: RAM contents as a queue, output stage, sticky error, read count
  logic [W-1:0] q[$];
  bit           m_ov;
  logic [W-1:0] m_od;
  bit           m_err;
  int           m_rd;

  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

  always @(posedge clk or posedge rst) begin : model
    bit was_full;
    bit xf;
    if (rst) begin
      q.delete();
      m_ov  = 0;
      m_od  = '0;
      m_err = 0;
      m_rd  = 0;
      wp   <= '0;
    end else if (bus.fifoFlush) begin
      q.delete();
      m_ov = 0;
      m_od = '0;
      m_rd = 0;
      wp  <= '0;
    end else begin
      was_full = (q.size() == DEPTH);
      xf = (q.size() > 0) && (!m_ov || bus.outReady);
      if (xf) begin
        m_od = q.pop_front();
        m_ov = 1;
        m_rd = (m_rd + 1) % DEPTH;
      end else if (m_ov && bus.outReady) begin
        m_ov = 0;
      end
      if (bus.fifoPush) begin
        if (was_full) m_err = 1;
        else begin
          q.push_back(pdata);
          mem[wp] <= pdata;
          wp      <= wp + 1'b1;
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("level", 64'(bus.fifoLevel), 64'(q.size()));
      cmp("full",  64'(bus.fifoFull),  64'(q.size() == DEPTH));
      cmp("empty", 64'(bus.fifoEmpty), 64'(q.size() == 0));
      cmp("valid", 64'(bus.outValid),  64'(m_ov));
      cmp("data",  64'(bus.outData),   64'(m_od));
      cmp("ovf",   64'(bus.overflowErr), 64'(m_err));
      cmp("rdaddr", 64'(bus.fifoRdAddr), 64'(m_rd * 4));
    end
  end

  task automatic cyc(input bit push, input logic [W-1:0] d,
                     input bit flush, input bit ready);
    bus.fifoPush  = push;
    pdata         = d;
    bus.fifoFlush = flush;
    bus.outReady  = ready;
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    cyc(0, '0, 1, 0);
  endtask

  initial begin
    bus.fifoPush  = 0;
    bus.fifoFlush = 0;
    bus.outReady  = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_level", 64'(bus.fifoLevel), 0);
    cmp("rst_empty", 64'(bus.fifoEmpty), 1);
    cmp("rst_valid", 64'(bus.outValid), 0);
    rst = 0;
    chk_en = 1;

    // single word latency
    cyc(1, 32'hA5A5A5A5, 0, 1);
    cmp("lat_lvl1", 64'(bus.fifoLevel), 1);
    cmp("lat_valid0", 64'(bus.outValid), 0);
    cyc(0, '0, 0, 1);
    cmp("lat_valid", 64'(bus.outValid), 1);
    cmp("lat_data", 64'(bus.outData), 64'hA5A5A5A5);
    cmp("lat_empty", 64'(bus.fifoEmpty), 1);
    cyc(0, '0, 0, 1);
    cmp("lat_gone", 64'(bus.outValid), 0);

    // fill to full with consumer stalled, then overflow
    do_flush();
    for (int k = 0; k < 8; k++) cyc(1, W'(k), 0, 0);
    cmp("fill_lvl7", 64'(bus.fifoLevel), 7);
    cmp("fill_out0", 64'(bus.outData), 0);
    cyc(1, 8, 0, 0);
    cmp("fill_lvl8", 64'(bus.fifoLevel), 8);
    cmp("fill_full", 64'(bus.fifoFull), 1);
    cyc(1, 32'hDEAD, 0, 0);
    cmp("ovf_set", 64'(bus.overflowErr), 1);
    cmp("ovf_lvl", 64'(bus.fifoLevel), 8);
    cyc(0, '0, 0, 1);
    cmp("full_clr", 64'(bus.fifoFull), 0);
    repeat (10) cyc(0, '0, 0, 1);

    // streaming across pointer wrap
    do_flush();
    for (int k = 0; k < 20; k++) begin
      cyc(1, W'(k), 0, 1);
      if (k >= 1) cmp("wrap_data", 64'(bus.outData), 64'(k - 1));
      if (k >= 1) cmp("wrap_valid", 64'(bus.outValid), 1);
      if (k == 7) cmp("wrap_a28", 64'(bus.fifoRdAddr), 28);
      if (k == 8) cmp("wrap_a0", 64'(bus.fifoRdAddr), 0);
    end
    repeat (3) cyc(0, '0, 0, 1);

    // backpressure 1,0,0,1
    for (int r = 0; r < 3; r++) begin
      cyc(1, W'(100 + 4*r), 0, 1);
      cyc(1, W'(101 + 4*r), 0, 0);
      cyc(1, W'(102 + 4*r), 0, 0);
      cyc(1, W'(103 + 4*r), 0, 1);
    end
    repeat (12) cyc(0, '0, 0, 1);

    // flush with level 4 and a coincident push
    do_flush();
    for (int k = 0; k < 5; k++) cyc(1, W'(k + 50), 0, 0);
    cmp("fl_pre_lvl", 64'(bus.fifoLevel), 4);
    cmp("fl_pre_val", 64'(bus.outValid), 1);
    cyc(1, 32'h77, 1, 0);
    cmp("fl_lvl", 64'(bus.fifoLevel), 0);
    cmp("fl_val", 64'(bus.outValid), 0);
    cmp("fl_addr", 64'(bus.fifoRdAddr), 0);
    cmp("fl_ovf_kept", 64'(bus.overflowErr), 1);
    cyc(0, '0, 0, 1);
    cmp("fl_lvl_after", 64'(bus.fifoLevel), 0);

    // asynchronous reset mid-stream
    for (int k = 0; k < 6; k++) cyc(1, W'(k + 60), 0, 0);
    cmp("ar_pre_lvl", 64'(bus.fifoLevel), 5);
    rst = 1;
    #1;
    cmp("ar_lvl", 64'(bus.fifoLevel), 0);
    cmp("ar_valid", 64'(bus.outValid), 0);
    cmp("ar_data", 64'(bus.outData), 0);
    cmp("ar_addr", 64'(bus.fifoRdAddr), 0);
    cmp("ar_ovf", 64'(bus.overflowErr), 0);
    cmp("ar_empty", 64'(bus.fifoEmpty), 1);
    @(posedge clk);
    #1;
    rst = 0;

    // randomized traffic with varying consumer pressure
    for (int b = 0; b < 8; b++) begin
      int thr;
      thr = (b % 4) * 30 + 10;
      for (int i = 0; i < 300; i++)
        cyc($urandom_range(0, 99) < 60, $urandom,
            $urandom_range(0, 99) == 0,
            $urandom_range(0, 99) < thr);
    end
    repeat (12) cyc(0, '0, 0, 1);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
